// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the main-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {REQ_IC, REQ_DC} req_id_t;

    localparam int unsigned ADDR_W_DEF = 26;
    localparam int unsigned DATA_W_DEF = 128;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester not granted last time wins.
module rr_pick2 (
    input  logic ic_req,
    input  logic dc_req,
    input  logic last_dc,
    output logic gnt_valid,
    output logic gnt_dc
);

    always_comb begin
        gnt_valid = ic_req | dc_req;
        gnt_dc    = dc_req & (~ic_req | ~last_dc);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single line-wide main-memory port between IC fill and DC fill/writeback,
// holding address/data for LATENCY cycles and pulsing done to the granted requester.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned LATENCY = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [DATA_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [DATA_W-1:0] dc_rdata,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    req_id_t           last_grant_q, last_grant_d;
    req_id_t           gnt_id_q, gnt_id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;
    logic              ic_done_q, ic_done_d;
    logic              dc_done_q, dc_done_d;
    logic              pick_valid;
    logic              pick_dc;

    rr_pick2 u_rr_pick2 (
        .ic_req    (ic_req),
        .dc_req    (dc_req),
        .last_dc   (last_grant_q == REQ_DC),
        .gnt_valid (pick_valid),
        .gnt_dc    (pick_dc)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        ic_rdata_d   = ic_rdata_q;
        dc_rdata_d   = dc_rdata_q;
        ic_done_d    = 1'b0;
        dc_done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_id_d     = pick_dc ? REQ_DC : REQ_IC;
                    last_grant_d = pick_dc ? REQ_DC : REQ_IC;
                    addr_d       = pick_dc ? dc_addr : ic_addr;
                    we_d         = pick_dc & dc_we;
                    wdata_d      = pick_dc ? dc_wdata : '0;
                    cnt_d        = CNT_INIT;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                // Final access cycle: capture read data so done lands one cycle later.
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (gnt_id_q == REQ_DC) begin
                        dc_done_d = 1'b1;
                        if (!we_q) begin
                            dc_rdata_d = mem_rdata;
                        end
                    end else begin
                        ic_done_d  = 1'b1;
                        ic_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= REQ_IC;
            gnt_id_q     <= REQ_IC;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            ic_rdata_q   <= '0;
            dc_rdata_q   <= '0;
            ic_done_q    <= 1'b0;
            dc_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            ic_rdata_q   <= ic_rdata_d;
            dc_rdata_q   <= dc_rdata_d;
            ic_done_q    <= ic_done_d;
            dc_done_q    <= dc_done_d;
        end
    end

    // Write strobe is gated by reset so an aborted writeback never commits.
    assign mem_we    = (state_q == BUSY) && (cnt_q == 4'd0) && we_q && !reset;
    assign mem_raddr = addr_q;
    assign mem_waddr = addr_q;
    assign mem_wdata = wdata_q;
    assign ic_done   = ic_done_q;
    assign dc_done   = dc_done_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: LATENCY=5 main instance plus a LATENCY=1 instance.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 26;
    localparam int unsigned DW = 128;

    typedef struct {
        bit            is_dc;
        logic [DW-1:0] data;
        int unsigned   due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          mem_load;
    logic          ic_req, dc_req, dc_we;
    logic [AW-1:0] ic_addr, dc_addr;
    logic [DW-1:0] dc_wdata;
    logic          ic_done, dc_done, mem_we, busy;
    logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_raddr, mem_waddr;

    logic          ic_req1, dc_req1, dc_we1;
    logic [AW-1:0] ic_addr1, dc_addr1;
    logic [DW-1:0] dc_wdata1;
    logic          ic_done1, dc_done1, mem_we1, busy1;
    logic [DW-1:0] ic_rdata1, dc_rdata1, mem_wdata1, mem_rdata1;
    logic [AW-1:0] mem_raddr1, mem_waddr1;

    logic [DW-1:0] mem     [16];
    logic [DW-1:0] mem1    [16];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] dc_model;
    exp_t          sb[$];
    exp_t          sb1[$];
    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;

    function automatic logic [DW-1:0] line_init(int unsigned n);
        return {32'(4 * n + 3), 32'(4 * n + 2), 32'(4 * n + 1), 32'(4 * n)};
    endfunction

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(5)) u_dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .dc_rdata(dc_rdata),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .ic_req(ic_req1), .ic_addr(ic_addr1), .ic_done(ic_done1), .ic_rdata(ic_rdata1),
        .dc_req(dc_req1), .dc_we(dc_we1), .dc_addr(dc_addr1), .dc_wdata(dc_wdata1),
        .dc_done(dc_done1), .dc_rdata(dc_rdata1),
        .mem_raddr(mem_raddr1), .mem_waddr(mem_waddr1), .mem_wdata(mem_wdata1),
        .mem_we(mem_we1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    assign mem_rdata  = mem[mem_raddr[3:0]];
    assign mem_rdata1 = mem1[mem_raddr1[3:0]];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= line_init(i);
        end else if (mem_we) begin
            mem[mem_waddr[3:0]] <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem1[i] <= line_init(i);
        end else if (mem_we1) begin
            mem1[mem_waddr1[3:0]] <= mem_wdata1;
        end
    end

    task automatic start_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        start_cycle();
        reset  = 1'b1;
        ic_req = 1'b0;
        dc_req = 1'b0;
        dc_we  = 1'b0;
        start_cycle();
        reset    = 1'b0;
        dc_model = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (ic_done !== 1'b0) $display("FAIL reset_ic_done: got %b expected 0", ic_done); else n_pass++;
        n_checks++; if (dc_done !== 1'b0) $display("FAIL reset_dc_done: got %b expected 0", dc_done); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", mem_we); else n_pass++;
        n_checks++; if (ic_rdata !== '0) $display("FAIL reset_ic_rdata: got %h expected 0", ic_rdata); else n_pass++;
        n_checks++; if (dc_rdata !== '0) $display("FAIL reset_dc_rdata: got %h expected 0", dc_rdata); else n_pass++;
        n_checks++; if (mem_raddr !== '0) $display("FAIL reset_mem_raddr: got %h expected 0", mem_raddr); else n_pass++;
        n_checks++; if (mem_wdata !== '0) $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); else n_pass++;
        n_checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy1: got %b expected 0", busy1); else n_pass++;
    endtask

    task automatic test_ic_only();
        exp_t        e;
        int unsigned we_seen = 0;
        start_cycle();
        ic_req  = 1'b1;
        ic_addr = 26'h5;
        sb.push_back('{is_dc: 1'b0, data: ref_mem[5], due: 6});
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (mem_we) we_seen++;
            if (k >= 1 && k <= 5) begin
                n_checks++;
                if (mem_raddr !== 26'h5) $display("FAIL ic_only_raddr: cycle %0d got %h expected 5", k, mem_raddr);
                else n_pass++;
            end
            if (k == 1 || k == 7) begin
                n_checks++;
                if (busy !== (k == 1)) $display("FAIL ic_only_busy: cycle %0d got %b expected %b", k, busy, k == 1);
                else n_pass++;
            end
            if (ic_done || dc_done) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL ic_only_done: unexpected done ic=%b dc=%b cycle %0d", ic_done, dc_done, k);
                end else begin
                    e = sb.pop_front();
                    if ({dc_done, ic_done} !== (e.is_dc ? 2'b10 : 2'b01) || k != e.due)
                        $display("FAIL ic_only_grant: got {dc,ic}=%b cycle %0d expected %b cycle %0d",
                                 {dc_done, ic_done}, k, (e.is_dc ? 2'b10 : 2'b01), e.due);
                    else n_pass++;
                    n_checks++;
                    if (ic_rdata !== e.data) $display("FAIL ic_only_data: got %h expected %h", ic_rdata, e.data);
                    else n_pass++;
                end
                ic_req = 1'b0;
            end
        end
        n_checks++; if (we_seen != 0) $display("FAIL ic_only_we: got %0d write cycles expected 0", we_seen); else n_pass++;
        n_checks++; if (sb.size() != 0) $display("FAIL ic_only_drain: got %0d pending expected 0", sb.size()); else n_pass++;
        sb.delete();
    endtask

    task automatic test_dc_wb_read();
        exp_t          e;
        int unsigned   we_cnt = 0;
        int            we_cyc = -1;
        logic [DW-1:0] wd;
        wd = {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
        for (int phase = 0; phase < 2; phase++) begin
            start_cycle();
            dc_req  = 1'b1;
            dc_we   = (phase == 0);
            dc_addr = 26'h3;
            if (phase == 0) begin
                dc_wdata   = wd;
                ref_mem[3] = wd;
                sb.push_back('{is_dc: 1'b1, data: dc_model, due: 6});
            end else begin
                dc_wdata = '0;
                dc_model = ref_mem[3];
                sb.push_back('{is_dc: 1'b1, data: ref_mem[3], due: 6});
            end
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (mem_we) begin
                    we_cnt++;
                    we_cyc = k;
                    n_checks++;
                    if (mem_waddr !== 26'h3 || mem_wdata !== wd)
                        $display("FAIL wb_bus: got addr %h data %h expected addr 3 data %h", mem_waddr, mem_wdata, wd);
                    else n_pass++;
                end
                if (ic_done || dc_done) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        $display("FAIL wb_done: unexpected done ic=%b dc=%b cycle %0d", ic_done, dc_done, k);
                    end else begin
                        e = sb.pop_front();
                        if ({dc_done, ic_done} !== (e.is_dc ? 2'b10 : 2'b01) || k != e.due)
                            $display("FAIL wb_grant: got {dc,ic}=%b cycle %0d expected %b cycle %0d",
                                     {dc_done, ic_done}, k, (e.is_dc ? 2'b10 : 2'b01), e.due);
                        else n_pass++;
                        n_checks++;
                        if (dc_rdata !== e.data) $display("FAIL wb_data: phase %0d got %h expected %h", phase, dc_rdata, e.data);
                        else n_pass++;
                    end
                    dc_req = 1'b0;
                    dc_we  = 1'b0;
                end
            end
            n_checks++; if (sb.size() != 0) $display("FAIL wb_drain: got %0d pending expected 0", sb.size()); else n_pass++;
            sb.delete();
        end
        n_checks++;
        if (we_cnt != 1 || we_cyc != 5) $display("FAIL wb_we_cycle: got %0d pulses last at %0d expected 1 at 5", we_cnt, we_cyc);
        else n_pass++;
        n_checks++; if (mem[3] !== wd) $display("FAIL wb_mem: got %h expected %h", mem[3], wd); else n_pass++;
    endtask

    task automatic test_simultaneous(input string tag, input logic [AW-1:0] ia, input logic [AW-1:0] da);
        exp_t e;
        start_cycle();
        ic_req  = 1'b1;
        ic_addr = ia;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = da;
        dc_model = ref_mem[da[3:0]];
        sb.push_back('{is_dc: 1'b1, data: ref_mem[da[3:0]], due: 6});
        sb.push_back('{is_dc: 1'b0, data: ref_mem[ia[3:0]], due: 13});
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (ic_done || dc_done) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL %s_done: unexpected done ic=%b dc=%b cycle %0d", tag, ic_done, dc_done, k);
                end else begin
                    e = sb.pop_front();
                    if ({dc_done, ic_done} !== (e.is_dc ? 2'b10 : 2'b01) || k != e.due)
                        $display("FAIL %s_grant: got {dc,ic}=%b cycle %0d expected %b cycle %0d",
                                 tag, {dc_done, ic_done}, k, (e.is_dc ? 2'b10 : 2'b01), e.due);
                    else n_pass++;
                    n_checks++;
                    if ((e.is_dc ? dc_rdata : ic_rdata) !== e.data)
                        $display("FAIL %s_data: got %h expected %h", tag, (e.is_dc ? dc_rdata : ic_rdata), e.data);
                    else n_pass++;
                end
                if (ic_done) ic_req = 1'b0;
                if (dc_done) dc_req = 1'b0;
            end
        end
        n_checks++; if (sb.size() != 0) $display("FAIL %s_drain: got %0d pending expected 0", tag, sb.size()); else n_pass++;
        sb.delete();
    endtask

    task automatic test_continuous();
        exp_t        e;
        int unsigned ic_cnt = 0;
        int unsigned dc_cnt = 0;
        start_cycle();
        ic_req  = 1'b1;
        ic_addr = 26'd4;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = 26'd7;
        // Last grant before this run was IC, so the sustained tie starts with DC.
        for (int j = 0; j < 6; j++) begin
            if (j % 2 == 0) sb.push_back('{is_dc: 1'b1, data: ref_mem[7 + j / 2], due: 6 + 7 * j});
            else            sb.push_back('{is_dc: 1'b0, data: ref_mem[4 + j / 2], due: 6 + 7 * j});
        end
        dc_model = ref_mem[9];
        for (int k = 0; k < 46; k++) begin
            @(negedge clk);
            if (ic_done || dc_done) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL cont_done: unexpected done ic=%b dc=%b cycle %0d", ic_done, dc_done, k);
                end else begin
                    e = sb.pop_front();
                    if ({dc_done, ic_done} !== (e.is_dc ? 2'b10 : 2'b01) || k != e.due)
                        $display("FAIL cont_grant: got {dc,ic}=%b cycle %0d expected %b cycle %0d",
                                 {dc_done, ic_done}, k, (e.is_dc ? 2'b10 : 2'b01), e.due);
                    else n_pass++;
                    n_checks++;
                    if ((e.is_dc ? dc_rdata : ic_rdata) !== e.data)
                        $display("FAIL cont_data: got %h expected %h", (e.is_dc ? dc_rdata : ic_rdata), e.data);
                    else n_pass++;
                end
                if (dc_done) begin
                    dc_cnt++;
                    if (dc_cnt < 3) dc_addr = AW'(7 + dc_cnt);
                    else dc_req = 1'b0;
                end
                if (ic_done) begin
                    ic_cnt++;
                    if (ic_cnt < 3) ic_addr = AW'(4 + ic_cnt);
                    else ic_req = 1'b0;
                end
            end
        end
        n_checks++; if (sb.size() != 0) $display("FAIL cont_drain: got %0d pending expected 0", sb.size()); else n_pass++;
        sb.delete();
    endtask

    task automatic test_reset_mid_busy();
        int unsigned done_seen = 0;
        start_cycle();
        dc_req   = 1'b1;
        dc_we    = 1'b1;
        dc_addr  = 26'd10;
        dc_wdata = {4{32'h5A5A_A5A5}};
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b0) $display("FAIL midrst_we: got %b expected 0", mem_we); else n_pass++;
        start_cycle();
        reset    = 1'b0;
        dc_req   = 1'b0;
        dc_we    = 1'b0;
        dc_model = '0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            if (dc_done || ic_done) done_seen++;
            @(negedge clk);
        end
        n_checks++; if (done_seen != 0) $display("FAIL midrst_done: got %0d pulses expected 0", done_seen); else n_pass++;
        n_checks++; if (mem[10] !== ref_mem[10]) $display("FAIL midrst_mem: got %h expected %h", mem[10], ref_mem[10]); else n_pass++;
        n_checks++; if (dc_rdata !== '0) $display("FAIL midrst_rdata: got %h expected 0", dc_rdata); else n_pass++;
    endtask

    task automatic test_latency1();
        exp_t        e;
        int unsigned seen = 0;
        start_cycle();
        ic_req1  = 1'b1;
        ic_addr1 = 26'd6;
        sb1.push_back('{is_dc: 1'b0, data: line_init(6), due: 2});
        sb1.push_back('{is_dc: 1'b0, data: line_init(6), due: 5});
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++;
                if (mem_raddr1 !== 26'd6 || busy1 !== 1'b1)
                    $display("FAIL lat1_busy1: got addr %h busy %b expected addr 6 busy 1", mem_raddr1, busy1);
                else n_pass++;
            end
            if (k == 3 || k == 4) begin
                n_checks++;
                if (busy1 !== (k == 4)) $display("FAIL lat1_gap: cycle %0d got busy %b expected %b", k, busy1, k == 4);
                else n_pass++;
            end
            if (ic_done1 || dc_done1) begin
                n_checks++;
                if (sb1.size() == 0) begin
                    $display("FAIL lat1_done: unexpected done ic=%b dc=%b cycle %0d", ic_done1, dc_done1, k);
                end else begin
                    e = sb1.pop_front();
                    if ({dc_done1, ic_done1} !== 2'b01 || k != e.due)
                        $display("FAIL lat1_grant: got {dc,ic}=%b cycle %0d expected 01 cycle %0d", {dc_done1, ic_done1}, k, e.due);
                    else n_pass++;
                    n_checks++;
                    if (ic_rdata1 !== e.data) $display("FAIL lat1_data: got %h expected %h", ic_rdata1, e.data);
                    else n_pass++;
                end
                seen++;
                if (seen == 2) ic_req1 = 1'b0;
            end
        end
        n_checks++; if (sb1.size() != 0) $display("FAIL lat1_drain: got %0d pending expected 0", sb1.size()); else n_pass++;
        sb1.delete();
    endtask

    initial begin
        reset     = 1'b1;
        mem_load  = 1'b1;
        ic_req    = 1'b0; ic_addr  = '0;
        dc_req    = 1'b0; dc_we    = 1'b0; dc_addr  = '0; dc_wdata  = '0;
        ic_req1   = 1'b0; ic_addr1 = '0;
        dc_req1   = 1'b0; dc_we1   = 1'b0; dc_addr1 = '0; dc_wdata1 = '0;
        dc_model  = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = line_init(i);
        repeat (2) @(posedge clk);
        #1;
        mem_load = 1'b0;
        reset    = 1'b0;

        test_reset();
        test_ic_only();
        test_dc_wb_read();
        apply_reset();
        test_simultaneous("simul", 26'd1, 26'd2);
        test_continuous();
        test_reset_mid_busy();
        test_simultaneous("postrst", 26'd11, 26'd12);
        test_latency1();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single 128-bit line-wide main-memory port between two requesters: instruction-cache fill (IC) and data-cache fill/writeback (DC).
- The main memory is combinational. This block models a fixed access latency by holding the address and data stable for LATENCY cycles.
- It commits writes with a single-cycle write-enable pulse, captures read data, and signals completion to the granted requester.
- It sits between both caches and the main memory.

Parameters:
- ADDR_W, 26, line address width (memory scales it to a word index internally).
- DATA_W, 128, line width.
- LATENCY, 5, memory access cycles per transaction; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- ic_req  in  1  IC fill request (level).
- ic_addr  in  ADDR_W  IC line address.
- ic_done  out  1  one-cycle pulse: ic_rdata valid.
- ic_rdata  out  DATA_W  IC fill data.
- dc_req  in  1  DC request (level).
- dc_we  in  1  1 = writeback, 0 = fill.
- dc_addr  in  ADDR_W  DC line address.
- dc_wdata  in  DATA_W  DC writeback data.
- dc_done  out  1  one-cycle pulse: DC transaction complete.
- dc_rdata  out  DATA_W  DC fill data.
- mem_raddr  out  ADDR_W  memory read address.
- mem_waddr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data (combinational from mem_raddr).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM has three states: IDLE, BUSY, DONE.
- Reset state: IDLE, cnt = 0, last_grant = IC, all address and data registers 0, ic_done = dc_done = 0, ic_rdata = dc_rdata = 0, mem_we = 0, busy = 0.
- Arbitration happens in IDLE only.
  - One requester high: grant it.
  - Both high: grant the requester not equal to last_grant (round-robin). After reset, DC therefore wins the first tie.
  - On grant: latch the granted id, address, we (IC is always read), and wdata; update last_grant; set cnt = LATENCY-1; go to BUSY.
- BUSY:
  - mem_raddr = mem_waddr = latched address; mem_wdata = latched data; all three are held constant throughout BUSY.
  - cnt decrements each cycle.
  - When cnt == 0: mem_we = latched_we && !reset, combinational and high for exactly this one cycle. For reads, mem_rdata is captured at this edge into the granted requester's rdata register. Next state is DONE.
- DONE:
  - The granted requester's done is high for exactly one cycle. Its rdata stays stable until that requester's next completed read.
  - A writeback's dc_done leaves dc_rdata unchanged.
  - No arbitration in DONE; next state is IDLE.
- Latency: req sampled in cycle 0 (IDLE); BUSY occupies cycles 1..LATENCY; done is high in cycle LATENCY+1. Back-to-back issue: the next grant is at the earliest cycle LATENCY+2.
- Requester rules: hold req, addr, we and wdata stable from assertion until done. Deassert req no later than the cycle after done, otherwise it is re-arbitrated as a new request.
- The non-granted requester's done never pulses. Its request stays pending and is served next (guaranteed by round-robin).
- Outside BUSY: mem_we = 0; memory address and data outputs hold their last values.
- Reset mid-BUSY: IDLE at the next edge, no done pulse, no write committed (mem_we is gated by reset), last_grant = IC.
- LATENCY = 1: BUSY lasts one cycle, and mem_we coincides with entry into BUSY.
- busy = (state != IDLE).

Decomposition:
- Package mem_arb_pkg holds: state_t enum {IDLE, BUSY, DONE}; req_id_t enum {REQ_IC, REQ_DC}; constants ADDR_W_DEF = 26 and DATA_W_DEF = 128.
- The two-way round-robin picker is isolated as sub-module rr_pick2, a combinational grant from two requests plus last_grant.
- Everything else stays in a single module.

Test Plan:
- IC only: ic_req = 1, ic_addr = 0x5, memory line 5 = {0x17, 0x16, 0x15, 0x14} → mem_raddr = 0x5 in cycles 1-5, ic_done in cycle 6 only, ic_rdata = 0x00000017_00000016_00000015_00000014, mem_we never high.
- DC writeback then read: dc_we = 1, dc_addr = 0x3, dc_wdata = 0xDEADBEEF_... → mem_we high exactly in cycle 5; then a DC fill of 0x3 returns the written line in dc_rdata.
- Simultaneous requests after reset → DC granted first (dc_done at cycle 6). IC granted in the next IDLE (cycle 7), ic_done at cycle 13. ic_done is never high before that.
- Continuous dual requests for 6 transactions → grants alternate DC, IC, DC, …; no requester is served twice in a row.
- Reset in cycle 5 of a DC writeback → mem_we stays 0, dc_done stays 0, memory unchanged, busy = 0 in the next cycle.
- LATENCY = 1 build, IC read → ic_done in cycle 2; the DONE→IDLE gap is preserved.
